// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection for the
// 5-stage 16-bit core. Captures decoded operands and control from ID, presents
// them to EX and inserts a single bubble when EX holds a load whose Rd is read
// by the instruction in ID.
// Optional feature: define HAZ_STATS_EN to build a saturating 16-bit counter of
// hazard bubbles on bubble_cnt; without it bubble_cnt is tied to zero.

module id_ex_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ifid_valid,
  input  logic [REG_W-1:0]   ifid_rs,
  input  logic [REG_W-1:0]   ifid_rt,
  input  logic [REG_W-1:0]   ifid_rd,
  input  logic               ifid_uses_rt,
  input  logic               ifid_regwrite,
  input  logic               ifid_memread,
  input  logic               ifid_memwrite,
  input  logic               ifid_memtoreg,
  input  logic               ifid_alusrc,
  input  logic [ALUOP_W-1:0] ifid_aluop,
  input  logic [DATA_W-1:0]  ifid_rdata1,
  input  logic [DATA_W-1:0]  ifid_rdata2,
  input  logic [DATA_W-1:0]  ifid_imm,
  input  logic [DATA_W-1:0]  ifid_pc2,
  input  logic               freeze,
  input  logic               flush,
  output logic               idex_valid,
  output logic [REG_W-1:0]   idex_rs,
  output logic [REG_W-1:0]   idex_rt,
  output logic [REG_W-1:0]   idex_rd,
  output logic               idex_uses_rt,
  output logic               idex_regwrite,
  output logic               idex_memread,
  output logic               idex_memwrite,
  output logic               idex_memtoreg,
  output logic               idex_alusrc,
  output logic [ALUOP_W-1:0] idex_aluop,
  output logic [DATA_W-1:0]  idex_rdata1,
  output logic [DATA_W-1:0]  idex_rdata2,
  output logic [DATA_W-1:0]  idex_imm,
  output logic [DATA_W-1:0]  idex_pc2,
  output logic               stall_if,
  output logic [15:0]        bubble_cnt
);

  // One EX-stage slot; the all-zero value is a NOP.
  typedef struct packed {
    logic               valid;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic               uses_rt;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic [DATA_W-1:0]  rdata1;
    logic [DATA_W-1:0]  rdata2;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  pc2;
  } idex_t;

  idex_t idex_d, idex_q;
  logic  hazard;
  logic  take_instr;

  // Load-use detection: EX holds a real load to a non-zero Rd that ID reads.
  always_comb begin
    hazard = idex_q.valid & idex_q.memread & (idex_q.rd != '0) & ifid_valid &
             ((idex_q.rd == ifid_rs) | (ifid_uses_rt & (idex_q.rd == ifid_rt)));
  end

  // A flush kills the instruction, so fetch must be free to refill IF/ID.
  assign stall_if = freeze | (hazard & ~flush);

  // Next EX slot: hold on freeze, otherwise load ID with control killed on bubbles.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    idex_d     = idex_q;
    take_instr = ifid_valid & ~flush & ~hazard;
    if (!freeze) begin
      // Operand and register fields are don't-care in a bubble, so load them
      // unconditionally and gate only what can cause architectural effects.
      idex_d.rs       = ifid_rs;
      idex_d.rt       = ifid_rt;
      idex_d.rd       = ifid_rd;
      idex_d.rdata1   = ifid_rdata1;
      idex_d.rdata2   = ifid_rdata2;
      idex_d.imm      = ifid_imm;
      idex_d.pc2      = ifid_pc2;
      idex_d.valid    = take_instr;
      idex_d.uses_rt  = ifid_uses_rt  & take_instr;
      idex_d.regwrite = ifid_regwrite & take_instr;
      idex_d.memread  = ifid_memread  & take_instr;
      idex_d.memwrite = ifid_memwrite & take_instr;
      idex_d.memtoreg = ifid_memtoreg & take_instr;
      idex_d.alusrc   = ifid_alusrc   & take_instr;
      idex_d.aluop    = ifid_aluop    & {ALUOP_W{take_instr}};
    end
  end

  // Pipeline register; async reset yields the all-zero NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign idex_valid    = idex_q.valid;
  assign idex_rs       = idex_q.rs;
  assign idex_rt       = idex_q.rt;
  assign idex_rd       = idex_q.rd;
  assign idex_uses_rt  = idex_q.uses_rt;
  assign idex_regwrite = idex_q.regwrite;
  assign idex_memread  = idex_q.memread;
  assign idex_memwrite = idex_q.memwrite;
  assign idex_memtoreg = idex_q.memtoreg;
  assign idex_alusrc   = idex_q.alusrc;
  assign idex_aluop    = idex_q.aluop;
  assign idex_rdata1   = idex_q.rdata1;
  assign idex_rdata2   = idex_q.rdata2;
  assign idex_imm      = idex_q.imm;
  assign idex_pc2      = idex_q.pc2;

`ifdef HAZ_STATS_EN
  logic [15:0] bubble_cnt_d, bubble_cnt_q;

  // Count only hazard bubbles actually inserted; saturate at all-ones.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!freeze && !flush && hazard && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  // Bubble counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_cnt_q <= 16'h0000;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven bench for id_ex_stage with a scoreboard queue of
// expected EX-slot contents, plus hand-written reset-mid-stall and counter
// saturation sequences. Honours HAZ_STATS_EN for bubble_cnt expectations.

module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        ifid_valid, ifid_uses_rt;
  logic [3:0]  ifid_rs, ifid_rt, ifid_rd, ifid_aluop;
  logic        ifid_regwrite, ifid_memread, ifid_memwrite, ifid_memtoreg, ifid_alusrc;
  logic [15:0] ifid_rdata1, ifid_rdata2, ifid_imm, ifid_pc2;
  logic        freeze, flush;
  logic        idex_valid, idex_uses_rt;
  logic [3:0]  idex_rs, idex_rt, idex_rd, idex_aluop;
  logic        idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc;
  logic [15:0] idex_rdata1, idex_rdata2, idex_imm, idex_pc2;
  logic        stall_if;
  logic [15:0] bubble_cnt;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_valid(ifid_valid), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rd(ifid_rd),
    .ifid_uses_rt(ifid_uses_rt), .ifid_regwrite(ifid_regwrite), .ifid_memread(ifid_memread),
    .ifid_memwrite(ifid_memwrite), .ifid_memtoreg(ifid_memtoreg), .ifid_alusrc(ifid_alusrc),
    .ifid_aluop(ifid_aluop), .ifid_rdata1(ifid_rdata1), .ifid_rdata2(ifid_rdata2),
    .ifid_imm(ifid_imm), .ifid_pc2(ifid_pc2), .freeze(freeze), .flush(flush),
    .idex_valid(idex_valid), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_uses_rt(idex_uses_rt), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .idex_memwrite(idex_memwrite), .idex_memtoreg(idex_memtoreg), .idex_alusrc(idex_alusrc),
    .idex_aluop(idex_aluop), .idex_rdata1(idex_rdata1), .idex_rdata2(idex_rdata2),
    .idex_imm(idex_imm), .idex_pc2(idex_pc2), .stall_if(stall_if), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-outcome kinds: load the ID instruction, hold (freeze),
  // hazard bubble (counted) or flush bubble (not counted).
  typedef enum logic [1:0] {K_LOAD, K_HOLD, K_BHAZ, K_BFL} kind_t;

  // ctl = {regwrite, memread, memwrite, memtoreg, alusrc}
  typedef struct {
    logic        v;
    logic [3:0]  rs, rt, rd;
    logic        urt;
    logic [4:0]  ctl;
    logic [3:0]  aluop;
    logic [15:0] tag;
    logic        frz, fl;
    logic        e_stall;
    kind_t       kind;
  } vec_t;

  typedef struct {
    logic        v;
    logic [3:0]  rs, rt, rd;
    logic        urt;
    logic [4:0]  ctl;
    logic [3:0]  aluop;
    logic [15:0] tag;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic v, logic [3:0] rs, logic [3:0] rt, logic [3:0] rd,
                              logic urt, logic [4:0] ctl, logic [3:0] aluop,
                              logic [15:0] tag, logic frz, logic fl,
                              logic e_stall, kind_t kind);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.rd = rd; r.urt = urt; r.ctl = ctl;
    r.aluop = aluop; r.tag = tag; r.frz = frz; r.fl = fl;
    r.e_stall = e_stall; r.kind = kind;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    ifid_valid    = r.v;
    ifid_rs       = r.rs;
    ifid_rt       = r.rt;
    ifid_rd       = r.rd;
    ifid_uses_rt  = r.urt;
    ifid_regwrite = r.ctl[4];
    ifid_memread  = r.ctl[3];
    ifid_memwrite = r.ctl[2];
    ifid_memtoreg = r.ctl[1];
    ifid_alusrc   = r.ctl[0];
    ifid_aluop    = r.aluop;
    ifid_rdata1   = r.tag;
    ifid_rdata2   = r.tag + 16'd1;
    ifid_imm      = r.tag + 16'd2;
    ifid_pc2      = r.tag + 16'd3;
    freeze        = r.frz;
    flush         = r.fl;
  endtask

  task automatic compare(input exp_t e, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    check({s, ".valid"}, idex_valid, e.v);
    check({s, ".ctl"}, {idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc}, e.ctl);
    if (e.v) begin
      check({s, ".regs"}, {idex_rs, idex_rt, idex_rd}, {e.rs, e.rt, e.rd});
      check({s, ".uses_rt"}, idex_uses_rt, e.urt);
      check({s, ".aluop"}, idex_aluop, e.aluop);
      check({s, ".rdata1"}, idex_rdata1, e.tag);
      check({s, ".rdata2"}, idex_rdata2, e.tag + 16'd1);
      check({s, ".imm"}, idex_imm, e.tag + 16'd2);
      check({s, ".pc2"}, idex_pc2, e.tag + 16'd3);
    end
  endtask

  localparam logic [4:0] C_LD  = 5'b11011;
  localparam logic [4:0] C_ALU = 5'b10000;
  localparam logic [4:0] C_ADI = 5'b10001;
  localparam logic [4:0] C_ST  = 5'b00101;

  vec_t        vecs[21];
  exp_t        prev_e, e, got;
  logic [15:0] bub_exp;
  logic [15:0] sat_exp;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            v  rs rt rd urt ctl    aluop tag       frz fl stall kind
    vecs[0]  = mk(1, 1, 2, 3, 0, C_LD,  0, 16'h0100, 0, 0, 0, K_LOAD); // load R3
    vecs[1]  = mk(1, 3, 4, 6, 1, C_ALU, 1, 16'h0200, 0, 0, 1, K_BHAZ); // add uses R3
    vecs[2]  = mk(1, 3, 4, 6, 1, C_ALU, 1, 16'h0200, 0, 0, 0, K_LOAD); // add enters EX
    vecs[3]  = mk(1, 1, 1, 0, 0, C_LD,  0, 16'h0300, 0, 0, 0, K_LOAD); // load R0
    vecs[4]  = mk(1, 0, 0, 7, 1, C_ALU, 2, 16'h0400, 0, 0, 0, K_LOAD); // reads R0: no stall
    vecs[5]  = mk(1, 2, 2, 5, 0, C_LD,  0, 16'h0500, 0, 0, 0, K_LOAD); // load R5
    vecs[6]  = mk(1, 1, 5, 6, 0, C_ADI, 3, 16'h0600, 0, 0, 0, K_LOAD); // rt=5 unused
    vecs[7]  = mk(1, 1, 1, 9, 0, C_LD,  0, 16'h0700, 0, 0, 0, K_LOAD); // load R9
    vecs[8]  = mk(1, 2, 9, 0, 1, C_ST,  0, 16'h0800, 0, 0, 1, K_BHAZ); // store reads R9
    vecs[9]  = mk(1, 2, 9, 0, 1, C_ST,  0, 16'h0800, 0, 0, 0, K_LOAD);
    vecs[10] = mk(0, 5, 5, 5, 1, 5'h1F, 7, 16'h0A00, 0, 0, 0, K_LOAD); // invalid ID
    vecs[11] = mk(1, 1, 1, 4, 0, C_LD,  0, 16'h0B00, 0, 0, 0, K_LOAD); // load R4
    vecs[12] = mk(1, 4, 0, 6, 0, C_ALU, 1, 16'h0C00, 0, 1, 0, K_BFL);  // hazard+flush
    vecs[13] = mk(1, 1, 1, 8, 0, C_LD,  0, 16'h0D00, 0, 0, 0, K_LOAD); // load R8
    vecs[14] = mk(1, 8, 0, 6, 0, C_ALU, 1, 16'h0E00, 1, 0, 1, K_HOLD); // freeze
    vecs[15] = mk(1, 8, 1, 7, 1, C_ADI, 2, 16'h0E10, 1, 1, 1, K_HOLD); // freeze+flush
    vecs[16] = mk(1, 3, 2, 1, 0, C_ST,  3, 16'h0E20, 1, 0, 1, K_HOLD); // freeze
    vecs[17] = mk(1, 8, 0, 6, 0, C_ALU, 1, 16'h0E30, 0, 0, 1, K_BHAZ); // hazard after freeze
    vecs[18] = mk(1, 8, 0, 6, 0, C_ALU, 1, 16'h0E30, 0, 0, 0, K_LOAD);
    vecs[19] = mk(1, 1, 1, 6, 0, C_LD,  0, 16'h0F00, 0, 0, 0, K_LOAD); // load R6
    vecs[20] = mk(0, 6, 6, 2, 1, C_ALU, 1, 16'h0F10, 0, 0, 0, K_LOAD); // invalid reads R6

    // Reset state
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 5'h0, 0, 16'h0000, 0, 0, 0, K_LOAD));
    #12;
    prev_e = '{v: 1'b0, rs: 4'h0, rt: 4'h0, rd: 4'h0, urt: 1'b0, ctl: 5'h0, aluop: 4'h0, tag: 16'h0};
    check("reset.valid", idex_valid, 1'b0);
    check("reset.ctl", {idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc}, 5'h0);
    check("reset.data", {idex_rdata1, idex_rdata2, idex_imm, idex_pc2}, 64'h0);
    check("reset.stall_if", stall_if, 1'b0);
    check("reset.bubble_cnt", bubble_cnt, 16'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    bub_exp = 16'h0;

    // Table-driven vectors through the scoreboard
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d.stall_if", i), stall_if, vecs[i].e_stall);
      case (vecs[i].kind)
        K_LOAD: begin
          e.v     = vecs[i].v;
          e.rs    = vecs[i].rs;
          e.rt    = vecs[i].rt;
          e.rd    = vecs[i].rd;
          e.urt   = vecs[i].urt;
          e.ctl   = vecs[i].v ? vecs[i].ctl : 5'h0;
          e.aluop = vecs[i].aluop;
          e.tag   = vecs[i].tag;
        end
        K_HOLD: e = prev_e;
        default: begin
          e     = prev_e;
          e.v   = 1'b0;
          e.ctl = 5'h0;
        end
      endcase
      if (vecs[i].kind == K_BHAZ) bub_exp = bub_exp + 16'd1;
      sb_q.push_back(e);
      prev_e = e;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        check($sformatf("v%0d.scoreboard_empty", i), 32'd1, 32'd0);
      end else begin
        got = sb_q.pop_front();
        compare(got, i);
      end
`ifdef HAZ_STATS_EN
      check($sformatf("v%0d.bubble_cnt", i), bubble_cnt, bub_exp);
`else
      check($sformatf("v%0d.bubble_cnt", i), bubble_cnt, 16'h0);
`endif
    end

    // Reset asserted mid-cycle during a load-use stall
    @(negedge clk);
    drive(mk(1, 1, 1, 3, 0, C_LD, 0, 16'h1100, 0, 0, 0, K_LOAD));
    @(negedge clk);
    drive(mk(1, 3, 0, 6, 0, C_ALU, 1, 16'h1200, 0, 0, 1, K_BHAZ));
    #1;
    check("rst_mid.stall_before", stall_if, 1'b1);
    check("rst_mid.valid_before", idex_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.valid", idex_valid, 1'b0);
    check("rst_mid.ctl", {idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc}, 5'h0);
    check("rst_mid.regs_data", {idex_rd, idex_rdata1, idex_pc2}, 36'h0);
    check("rst_mid.stall_if", stall_if, 1'b0);
    check("rst_mid.bubble_cnt", bubble_cnt, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter saturation: preload near the top, then add four hazard bubbles
`ifdef HAZ_STATS_EN
    force dut.bubble_cnt_q = 16'hFFFD;
    #1;
    release dut.bubble_cnt_q;
    sat_exp = 16'hFFFD;
`else
    sat_exp = 16'h0;
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(mk(1, 1, 1, 2, 0, C_LD, 0, 16'h2000, 0, 0, 0, K_LOAD));
      @(negedge clk);
      drive(mk(1, 2, 0, 6, 0, C_ALU, 1, 16'h2100, 0, 0, 1, K_BHAZ));
      #1;
      check($sformatf("sat%0d.stall_if", i), stall_if, 1'b1);
      @(posedge clk);
      #1;
`ifdef HAZ_STATS_EN
      if (sat_exp != 16'hFFFF) sat_exp = sat_exp + 16'd1;
`endif
      check($sformatf("sat%0d.bubble_cnt", i), bubble_cnt, sat_exp);
      check($sformatf("sat%0d.valid", i), idex_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
